// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory-bus signals of
// mem_port_arbiter. The master modport is the arbiter's view. The slave modport
// is the view of the requesters and the memory together.
interface mem_port_arbiter_if;
    // Fetch requester
    logic        IReq;
    logic [31:0] IAddr;
    logic        IReady;
    logic [31:0] IRdata;
    // Data requester
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWdata;
    logic [1:0]  DSize;
    logic        DReady;
    logic [31:0] DRdata;
    // Memory bus
    logic        MReq;
    logic        MWe;
    logic [31:0] MAddr;
    logic [31:0] MWdata;
    logic [1:0]  MSize;
    logic [31:0] MRdata;
    logic        MAck;
    // Status
    logic        ErrTimeout;

    modport master (
        input  IReq, IAddr, DReq, DWe, DAddr, DWdata, DSize, MRdata, MAck,
        output IReady, IRdata, DReady, DRdata,
        output MReq, MWe, MAddr, MWdata, MSize, ErrTimeout
    );

    modport slave (
        output IReq, IAddr, DReq, DWe, DAddr, DWdata, DSize, MRdata, MAck,
        input  IReady, IRdata, DReady, DRdata,
        input  MReq, MWe, MAddr, MWdata, MSize, ErrTimeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch and data accesses. Data accesses win arbitration. After
// MAX_D_BURST consecutive data grants with a fetch pending, one fetch grant is
// forced. Each access runs IDLE -> xBUSY -> IDLE. Ready pulses combinationally
// with MAck.
// Optional macro ARB_TIMEOUT_EN: aborts a busy access after TIMEOUT cycles
// without MAck. On abort it returns zero data and sets the sticky ErrTimeout.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} arbStateT;

    localparam int unsigned   DCNT_W = $clog2(MAX_D_BURST + 1);
    localparam logic [DCNT_W-1:0] D_MAX = DCNT_W'(MAX_D_BURST);

    if (MAX_D_BURST < 1 || TIMEOUT < 2) begin : gBadParams
        $error("mem_port_arbiter: requires MAX_D_BURST >= 1 and TIMEOUT >= 2");
    end

    arbStateT          state, stateNext;
    logic [DCNT_W-1:0] dcount, dcountNext;
    logic              mReqNext;
    logic              mWeNext;
    logic [31:0]       mAddrNext;
    logic [31:0]       mWdataNext;
    logic [1:0]        mSizeNext;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned     TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] waitCnt;
    logic          timeoutHit;
    logic          errTimeout;
`endif

    // Arbitration, operand capture and completion decode
    always_comb begin
        stateNext  = state;
        dcountNext = dcount;
        mReqNext   = bus.MReq;
        mWeNext    = bus.MWe;
        mAddrNext  = bus.MAddr;
        mWdataNext = bus.MWdata;
        mSizeNext  = bus.MSize;
        bus.IReady = 1'b0;
        bus.DReady = 1'b0;
        bus.IRdata = bus.MRdata;
        bus.DRdata = bus.MRdata;
`ifdef ARB_TIMEOUT_EN
        timeoutHit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.DReq && (!bus.IReq || dcount < D_MAX)) begin
                    stateNext  = DBUSY;
                    mReqNext   = 1'b1;
                    mWeNext    = bus.DWe;
                    mAddrNext  = bus.DAddr;
                    mWdataNext = bus.DWdata;
                    mSizeNext  = bus.DSize;
                    // The burst count only grows while a fetch is being held off.
                    if (!bus.IReq)
                        dcountNext = '0;
                    else if (dcount != D_MAX)
                        dcountNext = dcount + DCNT_W'(1);
                end else if (bus.IReq) begin
                    stateNext  = IBUSY;
                    mReqNext   = 1'b1;
                    mWeNext    = 1'b0;
                    mAddrNext  = bus.IAddr;
                    mSizeNext  = 2'b10;
                    dcountNext = '0;
                end
            end
            IBUSY: begin
                if (bus.MAck) begin
                    bus.IReady = 1'b1;
                    stateNext  = IDLE;
                    mReqNext   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (waitCnt == TLAST) begin
                    bus.IReady = 1'b1;
                    bus.IRdata = '0;
                    timeoutHit = 1'b1;
                    stateNext  = IDLE;
                    mReqNext   = 1'b0;
                end
`endif
            end
            DBUSY: begin
                if (bus.MAck) begin
                    bus.DReady = 1'b1;
                    stateNext  = IDLE;
                    mReqNext   = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (waitCnt == TLAST) begin
                    bus.DReady = 1'b1;
                    bus.DRdata = '0;
                    timeoutHit = 1'b1;
                    stateNext  = IDLE;
                    mReqNext   = 1'b0;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, burst counter and registered memory-bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dcount     <= '0;
            bus.MReq   <= 1'b0;
            bus.MWe    <= 1'b0;
            bus.MAddr  <= '0;
            bus.MWdata <= '0;
            bus.MSize  <= '0;
        end else begin
            state      <= stateNext;
            dcount     <= dcountNext;
            bus.MReq   <= mReqNext;
            bus.MWe    <= mWeNext;
            bus.MAddr  <= mAddrNext;
            bus.MWdata <= mWdataNext;
            bus.MSize  <= mSizeNext;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Busy-wait counter (zero in IDLE, so zero on BUSY entry) and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt    <= '0;
            errTimeout <= 1'b0;
        end else begin
            if (state == IDLE)
                waitCnt <= '0;
            else if (!bus.MAck)
                waitCnt <= waitCnt + TW'(1);
            if (timeoutHit)
                errTimeout <= 1'b1;
        end
    end

    assign bus.ErrTimeout = errTimeout;
`else
    assign bus.ErrTimeout = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven bench for mem_port_arbiter
// (MAX_D_BURST=2, TIMEOUT=8). The table holds per-cycle stimulus and the
// expected outputs for that cycle. Hand-written sequences cover the long wait,
// reset in the middle of an access, and the timeout case when ARB_TIMEOUT_EN
// is defined.
module tb_mem_port_arbiter;
    typedef struct {
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic [1:0]  dSize;
        logic        mAck;
        logic [31:0] mRdata;
        logic        eMReq;
        logic        eMWe;
        logic [31:0] eMAddr;
        logic [1:0]  eMSize;
        logic [31:0] eMWdata;
        logic        eIReady;
        logic        eDReady;
        logic [31:0] eRdata;
    } vecT;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned LAT = 5;
    localparam logic        EXP_ERR = 1'b1;
`else
    localparam int unsigned LAT = 10;
    localparam logic        EXP_ERR = 1'b0;
`endif

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    vecT  vecs[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_D_BURST(2),
        .TIMEOUT    (8)
    ) dut (
        .clk(clk),
        .rst(rstN),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for an issued access, ack it in its busy cycle, report {DReady, IReady}
    task automatic serveOne(output logic [1:0] kind);
        kind = 2'b00;
        for (int n = 0; n < 20 && !bus.MReq; n++) begin
            @(posedge clk); #1;
        end
        chk1("serve MReq", bus.MReq, 1'b1);
        if (bus.MReq) begin
            bus.MAck   = 1'b1;
            bus.MRdata = 32'h0;
            @(negedge clk);
            kind = {bus.DReady, bus.IReady};
            @(posedge clk); #1;
            bus.MAck = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] g1, g2, g3;
        checks = 0;
        errors = 0;

        // iReq iAddr  dReq dWe dAddr dWdata dSize mAck mRdata | eMReq eMWe eMAddr eMSize eMWdata eIReady eDReady eRdata
        vecs.push_back('{1'b0,32'h0,  1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b0,1'b0,32'h0,   2'd0,32'h0,  1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h100,1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b0,1'b0,32'h0,   2'd0,32'h0,  1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h100,1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b1,1'b0,32'h100, 2'd2,32'h0,  1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h100,1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b1,32'hE3A01005,1'b1,1'b0,32'h100,2'd2,32'h0,  1'b1,1'b0,32'hE3A01005});
        vecs.push_back('{1'b0,32'h0,  1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b0,1'b0,32'h100, 2'd2,32'h0,  1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b1,32'h2004,32'hAB, 2'd0,1'b0,32'h0,      1'b0,1'b0,32'h100, 2'd2,32'h0,  1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b1,32'h2004,32'hAB, 2'd0,1'b0,32'h0,      1'b1,1'b1,32'h2004,2'd0,32'hAB, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b1,32'h2004,32'hAB, 2'd0,1'b0,32'h0,      1'b1,1'b1,32'h2004,2'd0,32'hAB, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b1,32'h2004,32'hAB, 2'd0,1'b1,32'hDEADBEEF,1'b1,1'b1,32'h2004,2'd0,32'hAB, 1'b0,1'b1,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b1,32'h5A5A5A5A,1'b0,1'b1,32'h2004,2'd0,32'hAB, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b0,32'h3000,32'h55, 2'd2,1'b0,32'h0,      1'b0,1'b1,32'h2004,2'd0,32'hAB, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b0,32'h0,  1'b1,1'b0,32'h3000,32'h55, 2'd2,1'b1,32'h12345678,1'b1,1'b0,32'h3000,2'd2,32'h55, 1'b0,1'b1,32'h12345678});
        vecs.push_back('{1'b0,32'h0,  1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b0,1'b0,32'h3000,2'd2,32'h55, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h500, 32'h66, 2'd1,1'b0,32'h0,      1'b0,1'b0,32'h3000,2'd2,32'h55, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h500, 32'h66, 2'd1,1'b1,32'hAAAA0001,1'b1,1'b0,32'h500, 2'd1,32'h66, 1'b0,1'b1,32'hAAAA0001});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h504, 32'h66, 2'd1,1'b0,32'h0,      1'b0,1'b0,32'h500, 2'd1,32'h66, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h504, 32'h66, 2'd1,1'b1,32'hAAAA0002,1'b1,1'b0,32'h504, 2'd1,32'h66, 1'b0,1'b1,32'hAAAA0002});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h508, 32'h66, 2'd1,1'b0,32'h0,      1'b0,1'b0,32'h504, 2'd1,32'h66, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h400,1'b1,1'b0,32'h508, 32'h66, 2'd1,1'b1,32'hBBBB0001,1'b1,1'b0,32'h400, 2'd2,32'h66, 1'b1,1'b0,32'hBBBB0001});
        vecs.push_back('{1'b1,32'h404,1'b1,1'b0,32'h508, 32'h66, 2'd1,1'b0,32'h0,      1'b0,1'b0,32'h400, 2'd2,32'h66, 1'b0,1'b0,32'h0});
        vecs.push_back('{1'b1,32'h404,1'b1,1'b0,32'h508, 32'h66, 2'd1,1'b1,32'hAAAA0003,1'b1,1'b0,32'h508, 2'd1,32'h66, 1'b0,1'b1,32'hAAAA0003});
        vecs.push_back('{1'b0,32'h0,  1'b0,1'b0,32'h0,   32'h0,  2'd0,1'b0,32'h0,      1'b0,1'b0,32'h508, 2'd1,32'h66, 1'b0,1'b0,32'h0});

        // Reset values
        rstN = 1'b0;
        bus.IReq = 1'b0; bus.IAddr = '0; bus.DReq = 1'b0; bus.DWe = 1'b0;
        bus.DAddr = '0; bus.DWdata = '0; bus.DSize = '0; bus.MAck = 1'b0; bus.MRdata = '0;
        @(negedge clk);
        chk1 ("reset MReq", bus.MReq, 1'b0);
        chk1 ("reset MWe", bus.MWe, 1'b0);
        chk32("reset MAddr", bus.MAddr, 32'h0);
        chk32("reset MWdata", bus.MWdata, 32'h0);
        chk32("reset MSize", {30'd0, bus.MSize}, 32'h0);
        chk1 ("reset IReady", bus.IReady, 1'b0);
        chk1 ("reset DReady", bus.DReady, 1'b0);
        chk1 ("reset ErrTimeout", bus.ErrTimeout, 1'b0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Per-cycle vector table
        foreach (vecs[i]) begin
            bus.IReq = vecs[i].iReq;   bus.IAddr = vecs[i].iAddr;
            bus.DReq = vecs[i].dReq;   bus.DWe = vecs[i].dWe;
            bus.DAddr = vecs[i].dAddr; bus.DWdata = vecs[i].dWdata; bus.DSize = vecs[i].dSize;
            bus.MAck = vecs[i].mAck;   bus.MRdata = vecs[i].mRdata;
            @(negedge clk);
            chk1 ($sformatf("v%0d MReq", i), bus.MReq, vecs[i].eMReq);
            chk1 ($sformatf("v%0d MWe", i), bus.MWe, vecs[i].eMWe);
            chk32($sformatf("v%0d MAddr", i), bus.MAddr, vecs[i].eMAddr);
            chk32($sformatf("v%0d MSize", i), {30'd0, bus.MSize}, {30'd0, vecs[i].eMSize});
            chk32($sformatf("v%0d MWdata", i), bus.MWdata, vecs[i].eMWdata);
            chk1 ($sformatf("v%0d IReady", i), bus.IReady, vecs[i].eIReady);
            chk1 ($sformatf("v%0d DReady", i), bus.DReady, vecs[i].eDReady);
            if (vecs[i].eIReady)
                chk32($sformatf("v%0d IRdata", i), bus.IRdata, vecs[i].eRdata);
            if (vecs[i].eDReady && !vecs[i].dWe)
                chk32($sformatf("v%0d DRdata", i), bus.DRdata, vecs[i].eRdata);
            @(posedge clk); #1;
        end

        // Long memory latency: bus held stable, exactly one Ready at MAck
        bus.IReq = 1'b1; bus.IAddr = 32'h700; bus.MAck = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk1 ($sformatf("lat%0d MReq", k), bus.MReq, 1'b1);
            chk32($sformatf("lat%0d MAddr", k), bus.MAddr, 32'h700);
            chk1 ($sformatf("lat%0d IReady", k), bus.IReady, 1'b0);
            @(posedge clk); #1;
        end
        bus.MAck = 1'b1; bus.MRdata = 32'hCAFEF00D;
        @(negedge clk);
        chk1 ("lat IReady", bus.IReady, 1'b1);
        chk32("lat IRdata", bus.IRdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus.MAck = 1'b0; bus.IReq = 1'b0;
        @(negedge clk);
        chk1("lat MReq drop", bus.MReq, 1'b0);
        chk1("lat no 2nd IReady", bus.IReady, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a data access (granted while a fetch was pending)
        bus.IReq = 1'b1; bus.IAddr = 32'h404;
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h900; bus.DWdata = 32'h77; bus.DSize = 2'd2;
        @(posedge clk); #1;
        chk1("rst pre MReq", bus.MReq, 1'b1);
        #2 rstN = 1'b0;
        #1;
        chk1 ("rst async MReq", bus.MReq, 1'b0);
        chk1 ("rst async MWe", bus.MWe, 1'b0);
        chk32("rst async MAddr", bus.MAddr, 32'h0);
        chk32("rst async MWdata", bus.MWdata, 32'h0);
        bus.MAck = 1'b1;
        @(negedge clk);
        chk1("rst DReady", bus.DReady, 1'b0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        chk1("rst stray DReady", bus.DReady, 1'b0);
        chk1("rst stray IReady", bus.IReady, 1'b0);
        @(posedge clk); #1;
        bus.MAck = 1'b0;
        // With the burst count cleared by reset, two data grants precede the fetch
        serveOne(g1);
        serveOne(g2);
        serveOne(g3);
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        chk32("post-reset grant order", {26'd0, g1, g2, g3}, 32'h0000_0029);
        @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
        // No MAck: abort in the 8th busy cycle with zero data
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h800; bus.DSize = 2'd2;
        bus.MAck = 1'b0; bus.MRdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk1($sformatf("to%0d DReady", k), bus.DReady, (k == 8));
            if (k == 8)
                chk32("to DRdata", bus.DRdata, 32'h0);
            @(posedge clk); #1;
        end
        bus.DReq = 1'b0;
        @(negedge clk);
        chk1("to MReq drop", bus.MReq, 1'b0);
        chk1("to ErrTimeout", bus.ErrTimeout, 1'b1);
        @(posedge clk); #1;
        bus.IReq = 1'b1; bus.IAddr = 32'hA00;
        @(posedge clk); #1;
        bus.MAck = 1'b1; bus.MRdata = 32'h11223344;
        @(negedge clk);
        chk1 ("to next IReady", bus.IReady, 1'b1);
        chk32("to next IRdata", bus.IRdata, 32'h11223344);
        @(posedge clk); #1;
        bus.MAck = 1'b0; bus.IReq = 1'b0;
        @(posedge clk); #1;
`endif

        @(negedge clk);
        chk1("final ErrTimeout", bus.ErrTimeout, EXP_ERR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
